// File: rtl/sample_window_sum.sv
// sample_window_sum: counts sample change events (mode 0) or sums the new
// sample values (mode 1) over windows of WINDOW events. Each completed window
// is presented on a valid/ready output. Later windows are dropped while the
// consumer stalls, and overrun records that.
module sample_window_sum #(
    parameter int SAMPLE_W = 4,
    parameter int WINDOW   = 8,
    parameter int SUM_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SAMPLE_W-1:0]        sample,
    input  logic                       mode,
    input  logic                       clear,
    output logic [SUM_W-1:0]           result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WINDOW)-1:0]  phase,
    output logic                       sat,
    output logic                       overrun
);

    localparam int PHASE_W = $clog2(WINDOW);
    localparam int EXT_W   = ((SUM_W > SAMPLE_W) ? SUM_W : SAMPLE_W) + 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WINDOW - 1);

    // Saturating add: returns {overflow, clamped sum}.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0]    a,
                                               input logic [SAMPLE_W-1:0] b);
        logic [EXT_W-1:0] full;
        full = EXT_W'(a) + EXT_W'(b);
        if (full > EXT_W'({SUM_W{1'b1}}))
            return {1'b1, {SUM_W{1'b1}}};
        else
            return {1'b0, full[SUM_W-1:0]};
    endfunction

    logic [SAMPLE_W-1:0] sample_q;
    logic                primed;
    logic                evt_q;
    logic [SAMPLE_W-1:0] val_q;
    logic [SUM_W-1:0]    acc;
    logic                mode_q;
    logic                win_sat;

    logic                handshake;
    logic                mode_eff;
    logic [SAMPLE_W-1:0] inc;
    logic [SUM_W:0]      add_res;
    logic                win_sat_next;
    logic                complete;

    // Stage 0: register the sample and detect changes after the first post-reset cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
            primed   <= 1'b0;
            evt_q    <= 1'b0;
            val_q    <= '0;
        end else begin
            sample_q <= sample;
            primed   <= 1'b1;
            evt_q    <= primed && (sample != sample_q);
            val_q    <= sample;
        end
    end

    // Next accumulator value and window-completion decode for the pending event.
    always_comb begin
        handshake    = out_valid & out_ready;
        mode_eff     = (phase == '0) ? mode : mode_q;
        inc          = mode_eff ? val_q : SAMPLE_W'(1);
        add_res      = sat_add(acc, inc);
        win_sat_next = win_sat | add_res[SUM_W];
        complete     = evt_q & ~clear & (phase == LAST_PHASE);
    end

    // Stage 1: accumulate events into the current window; clear aborts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            phase   <= '0;
            mode_q  <= 1'b0;
            win_sat <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            phase   <= '0;
            win_sat <= 1'b0;
        end else if (evt_q) begin
            if (phase == '0)
                mode_q <= mode;
            if (phase == LAST_PHASE) begin
                acc     <= '0;
                phase   <= '0;
                win_sat <= 1'b0;
            end else begin
                acc     <= add_res[SUM_W-1:0];
                phase   <= phase + 1'b1;
                win_sat <= win_sat_next;
            end
        end
    end

    // Stage 2: hold the completed window until accepted; drop and flag it on a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result    <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (handshake)
                overrun <= 1'b0;
            if (complete) begin
                if (!out_valid || handshake) begin
                    result    <= add_res[SUM_W-1:0];
                    sat       <= win_sat_next;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_window_sum.sv
// Bench for sample_window_sum: directed scenarios plus random traffic, run on
// a default instance and on a narrow-accumulator instance (SUM_W=6). Both are
// compared every cycle against a window-level reference model.
module tb_sample_window_sum;

    localparam int SAMPLE_W = 4;
    localparam int WINDOW   = 8;

    logic                clk;
    logic                reset_n;
    logic [SAMPLE_W-1:0] sample;
    logic                mode;
    logic                clear;
    logic                out_ready;

    logic [7:0] result_a;
    logic       out_valid_a, sat_a, overrun_a;
    logic [2:0] phase_a;
    logic [5:0] result_b;
    logic       out_valid_b, sat_b, overrun_b;
    logic [2:0] phase_b;

    int n_chk = 0;
    int n_err = 0;

    sample_window_sum #(.SAMPLE_W(SAMPLE_W), .WINDOW(WINDOW), .SUM_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .sample(sample), .mode(mode), .clear(clear),
        .result(result_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .phase(phase_a), .sat(sat_a), .overrun(overrun_a)
    );

    sample_window_sum #(.SAMPLE_W(SAMPLE_W), .WINDOW(WINDOW), .SUM_W(6)) dut6 (
        .clk(clk), .reset_n(reset_n), .sample(sample), .mode(mode), .clear(clear),
        .result(result_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .phase(phase_b), .sat(sat_b), .overrun(overrun_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: event stream -> windows of WINDOW events
    int m_prev;
    bit m_primed;
    bit m_pend;
    int m_pval;
    int m_cnt[2];
    int m_total[2];
    bit m_wmode[2];
    int m_res[2];
    bit m_ov[2];
    bit m_st[2];
    bit m_orun[2];
    int m_max[2] = '{255, 63};

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_primed = 0; m_pend = 0; m_pval = 0;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_total[m] = 0; m_wmode[m] = 0;
            m_res[m] = 0; m_ov[m] = 0; m_st[m] = 0; m_orun[m] = 0;
        end
    endtask

    task automatic model_step();
        bit hs, done, fs;
        int fv;
        if (!reset_n) return;
        for (int m = 0; m < 2; m++) begin
            hs = m_ov[m] && out_ready;
            done = 0; fv = 0; fs = 0;
            if (clear) begin
                m_cnt[m] = 0; m_total[m] = 0;
            end else if (m_pend) begin
                if (m_cnt[m] == 0) m_wmode[m] = mode;
                m_total[m] += m_wmode[m] ? m_pval : 1;
                m_cnt[m]++;
                if (m_cnt[m] == WINDOW) begin
                    done = 1;
                    fv = (m_total[m] > m_max[m]) ? m_max[m] : m_total[m];
                    fs = (m_total[m] > m_max[m]);
                    m_cnt[m] = 0; m_total[m] = 0;
                end
            end
            if (hs) m_orun[m] = 0;
            if (done) begin
                if (!m_ov[m] || hs) begin
                    m_res[m] = fv; m_st[m] = fs; m_ov[m] = 1;
                end else begin
                    m_orun[m] = 1;
                end
            end else if (hs) begin
                m_ov[m] = 0;
            end
        end
        m_pend   = m_primed && (int'(sample) != m_prev);
        m_pval   = int'(sample);
        m_prev   = int'(sample);
        m_primed = 1;
    endtask

    task automatic compare_all();
        check("result8",  int'(result_a),    m_res[0]);
        check("valid8",   int'(out_valid_a), int'(m_ov[0]));
        check("phase8",   int'(phase_a),     m_cnt[0]);
        check("sat8",     int'(sat_a),       int'(m_st[0]));
        check("overrun8", int'(overrun_a),   int'(m_orun[0]));
        check("result6",  int'(result_b),    m_res[1]);
        check("valid6",   int'(out_valid_b), int'(m_ov[1]));
        check("phase6",   int'(phase_b),     m_cnt[1]);
        check("sat6",     int'(sat_b),       int'(m_st[1]));
        check("overrun6", int'(overrun_b),   int'(m_orun[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_result", int'(result_a), 0);
        check("rst_valid", int'(out_valid_a), 0);
        check("rst_phase", int'(phase_a), 0);
        check("rst_flags", int'({sat_a, overrun_a}), 0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic toggles(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample = sample ^ SAMPLE_W'(1);
            for (int j = 0; j < gap; j++) tick();
        end
    endtask

    initial begin
        reset_n = 1'b0; sample = '0; mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);

        // Count mode, one window, consumer ready
        do_reset();
        tick();
        toggles(8, 2);
        tick(); tick();
        check("s1_result", int'(result_a), 8);
        check("s1_phase", int'(phase_a), 0);

        // Sum mode, samples 1..8
        do_reset();
        mode = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            sample = SAMPLE_W'(k);
            tick();
        end
        tick(); tick();
        check("s2_result", int'(result_a), 36);
        check("s2_sat", int'(sat_a), 0);

        // Sum mode, 15/14 alternating, both accumulator widths
        sample = '0;
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            sample = (k % 2 == 0) ? SAMPLE_W'(15) : SAMPLE_W'(14);
            tick();
        end
        out_ready = 1'b0;
        tick(); tick();
        check("s3_result8", int'(result_a), 116);
        check("s3_sat8", int'(sat_a), 0);
        check("s3_result6", int'(result_b), 63);
        check("s3_sat6", int'(sat_b), 1);

        // Stalled consumer over two windows -> overrun
        sample = '0; mode = 1'b0; out_ready = 1'b0;
        do_reset();
        tick();
        toggles(16, 2);
        tick();
        check("s4_result", int'(result_a), 8);
        check("s4_valid", int'(out_valid_a), 1);
        check("s4_overrun", int'(overrun_a), 1);
        out_ready = 1'b1;
        tick();
        check("s4_valid_drop", int'(out_valid_a), 0);
        check("s4_overrun_clr", int'(overrun_a), 0);

        // Clear at phase 5, coincident with an event
        do_reset();
        tick();
        toggles(5, 2);
        check("s5_phase5", int'(phase_a), 5);
        sample = sample ^ SAMPLE_W'(1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s5_phase0", int'(phase_a), 0);
        check("s5_novalid", int'(out_valid_a), 0);
        toggles(8, 2);
        tick();
        check("s5_result", int'(result_a), 8);

        // Reset mid-window with sample=9 held through release
        do_reset();
        tick();
        toggles(3, 2);
        check("s6_phase3", int'(phase_a), 3);
        sample = SAMPLE_W'(9);
        do_reset();
        tick();
        check("s6_phase_rel", int'(phase_a), 0);
        tick();
        check("s6_phase_after", int'(phase_a), 0);
        check("s6_valid", int'(out_valid_a), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) != 0) sample = SAMPLE_W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 39) == 0);
            out_ready = 1'($urandom_range(0, 1));
            if (c == 1500) begin
                clear = 1'b0;
                do_reset();
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_window_sum.md
SAMPLE_WINDOW_SUM -- requirements
Module: sample_window_sum

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 4: width of the sample input.
REQ-002 SHALL have parameter WINDOW, default 8: number of change events per window; legal range 2..256.
REQ-003 SHALL have parameter SUM_W, default 8: width of the accumulator and result.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sample, input, SAMPLE_W: monitored sample value, synchronous to clk.
REQ-007 SHALL have port mode, input, 1: 0 counts change events, 1 sums the new sample values; sampled only at window start.
REQ-008 SHALL have port clear, input, 1: synchronous abort of the current window.
REQ-009 SHALL have port result, output, SUM_W: window result, valid while out_valid=1.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port phase, output, clog2(WINDOW): number of events taken so far in the current window.
REQ-013 SHALL have port sat, output, 1: sticky; a saturation occurred in the window now held in result.
REQ-014 SHALL have port overrun, output, 1: sticky; a completed window was dropped.

Function
REQ-015 SHALL register sample into sample_q every cycle.
REQ-016 SHALL suppress event detection on the first cycle after reset release (primed flag) so that no event is taken for the post-reset load.
REQ-017 SHALL detect an event when primed=1 and sample != sample_q; the event and the new sample value are registered (evt_q, val_q), giving 1-cycle detect latency.
REQ-018 SHALL, on evt_q, add 1 (mode 0) or zero-extended val_q (mode 1) to acc and increment phase.
REQ-019 SHALL saturate acc at 2^SUM_W-1 rather than wrap, and set the window saturation bit.
REQ-020 SHALL latch the mode used for the window (mode_q) when phase=0 and evt_q=1; mode changes mid-window are ignored.
REQ-021 SHALL, on the evt_q that takes phase from WINDOW-1 back to 0, load result with the final acc value (including that event), set out_valid on the next edge, clear acc to 0, and wrap phase to 0.
REQ-022 SHALL hold result, sat and out_valid stable until a cycle with out_valid=1 and out_ready=1; out_valid deasserts on the following edge.
REQ-023 SHALL, when a window completes while out_valid=1 and no handshake occurs that cycle, keep the old result, drop the new one, and set overrun.
REQ-024 SHALL, when completion and handshake coincide, load the new result and keep out_valid=1 (back-to-back).
REQ-025 SHALL clear overrun only on a successful handshake.
REQ-026 SHALL, on clear=1, zero acc, phase and the window saturation bit without producing a result; clear has priority over a simultaneous evt_q; result, out_valid, sat and overrun are unaffected.
REQ-027 SHALL ignore out_ready while out_valid=0.

Reset
REQ-028 SHALL, while reset_n=0, force sample_q=0, evt_q=0, val_q=0, primed=0, acc=0, phase=0, mode_q=0, result=0, out_valid=0, sat=0 and overrun=0.
REQ-029 SHALL discard any partial window on reset asserted mid-operation; no result is produced for it.

Verification
REQ-030 Scenario: mode=0, WINDOW=8, sample toggles 0/1 every 2 cycles for 8 changes with out_ready=1 -> result=8, out_valid high for one cycle, phase returns to 0.
REQ-031 Scenario: mode=1, sample steps 1,2,...,8 once per cycle from 0 -> result=36, sat=0.
REQ-032 Scenario: mode=1, sample alternates 15/14 for 8 changes -> result=116 with no saturation; repeat with SUM_W=6 -> result=63, sat=1.
REQ-033 Scenario: out_ready=0, two full mode-0 windows -> result=8 retained, overrun=1; then out_ready=1 -> out_valid drops and overrun clears.
REQ-034 Scenario: clear pulsed at phase=5 and coincident with an event -> phase=0, acc=0, no out_valid; next 8 events -> result=8.
REQ-035 Scenario: reset_n low at phase=3, sample=9 held during release -> no event on the first post-release cycle, phase=0, all outputs at reset values.
